// File: rtl/crossbar_seq.sv
// Command sequencer for the 8x8 ReRAM crossbar MAC array.
// Turns WRITE/FORM/MAC/CLEAR commands into timed bitline/wordline/selectline
// pulses, samples the array's row-OR output and returns MAC results on a
// valid/ready response channel. All line outputs are registered.
// Optional write-verify with retries: define CROSSBAR_SEQ_VERIFY_EN.
module crossbar_seq #(
  parameter int unsigned PULSE_CYCLES = 4,
  parameter int unsigned SAMPLE_LAT   = 2
`ifdef CROSSBAR_SEQ_VERIFY_EN
  ,
  parameter int unsigned MAX_RETRY    = 3
`endif
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [1:0] cmd_op_i,
  input  logic [2:0] cmd_row_i,
  input  logic [7:0] cmd_data_i,
  output logic       rsp_valid_o,
  input  logic       rsp_ready_i,
  output logic [7:0] rsp_data_o,
  output logic       rsp_err_o,
  output logic       busy_o,
  output logic [7:0] xb_bitline_o,
  output logic [7:0] xb_wordline_o,
  output logic [7:0] xb_selectline_o,
  output logic       xb_wenable_o,
  output logic       xb_form_o,
  output logic       xb_mac_o,
  input  logic [7:0] xb_out_i
);

  localparam int unsigned CntMax = (PULSE_CYCLES > SAMPLE_LAT) ? PULSE_CYCLES : SAMPLE_LAT;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [2:0] {StIdle, StSet, StReset, StRead, StWait, StResp} state_e;
  typedef enum logic [1:0] {OpWrite = 2'b00, OpForm = 2'b01, OpMac = 2'b10, OpClear = 2'b11} op_e;

  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    onehot8 = 8'h01 << idx;
  endfunction

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic [2:0]      row_q, row_d;
  logic [7:0]      data_q, data_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [7:0]      rsp_data_q, rsp_data_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            busy_q, busy_d;
  logic [7:0]      bl_q, bl_d, wl_q, wl_d, sl_q, sl_d;
  logic            wen_q, wen_d, form_q, form_d, mac_q, mac_d;

`ifdef CROSSBAR_SEQ_VERIFY_EN
  localparam int unsigned RetryW = $clog2(MAX_RETRY + 1);

  logic [RetryW-1:0] retry_q, retry_d;
  logic              rsp_err_q, rsp_err_d;
  logic              mismatch;

  // Read-back of the written row must agree with whether any column was set.
  assign mismatch  = xb_out_i[row_q] != (|data_q);
  assign rsp_err_o = rsp_err_q;
`else
  assign rsp_err_o = 1'b0;
`endif

  // Next-state logic: sequencing, pulse/latency counters and response capture.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    row_d       = row_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
`ifdef CROSSBAR_SEQ_VERIFY_EN
    retry_d     = retry_q;
    rsp_err_d   = rsp_err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i && cmd_ready_q) begin
          op_d   = op_e'(cmd_op_i);
          row_d  = cmd_row_i;
          data_d = cmd_data_i;
`ifdef CROSSBAR_SEQ_VERIFY_EN
          retry_d = '0;
`endif
          unique case (op_e'(cmd_op_i))
            OpWrite, OpForm: begin
              state_d = StSet;
              cnt_d   = CntW'(PULSE_CYCLES - 1);
            end
            OpMac:   state_d = StRead;
            OpClear: begin
              state_d = StReset;
              cnt_d   = CntW'(PULSE_CYCLES - 1);
            end
            default: state_d = StIdle;
          endcase
        end
      end
      StSet: begin
        if (cnt_q == '0) begin
          if (op_q == OpForm) begin
            state_d = StIdle;
          end else begin
            state_d = StReset;
            cnt_d   = CntW'(PULSE_CYCLES - 1);
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StReset: begin
        if (cnt_q == '0) begin
`ifdef CROSSBAR_SEQ_VERIFY_EN
          state_d = (op_q == OpWrite) ? StRead : StIdle;
`else
          state_d = StIdle;
`endif
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StRead: begin
        state_d = StWait;
        cnt_d   = CntW'(SAMPLE_LAT);
      end
      StWait: begin
        if (cnt_q == '0) begin
`ifdef CROSSBAR_SEQ_VERIFY_EN
          if (op_q == OpMac) begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_data_d  = xb_out_i;
            rsp_err_d   = 1'b0;
          end else if (mismatch && (retry_q < RetryW'(MAX_RETRY))) begin
            retry_d = retry_q + RetryW'(1);
            state_d = StSet;
            cnt_d   = CntW'(PULSE_CYCLES - 1);
          end else begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_data_d  = 8'h00;
            rsp_err_d   = mismatch;
          end
`else
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_data_d  = xb_out_i;
`endif
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp: begin
        if (rsp_ready_i) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
          rsp_data_d  = 8'h00;
`ifdef CROSSBAR_SEQ_VERIFY_EN
          rsp_err_d   = 1'b0;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line and handshake outputs decoded from the next state so they register in step with it.
  always_comb begin
    bl_d        = 8'h00;
    wl_d        = 8'h00;
    sl_d        = 8'h00;
    wen_d       = 1'b0;
    form_d      = 1'b0;
    mac_d       = 1'b0;
    cmd_ready_d = (state_d == StIdle);
    busy_d      = (state_d != StIdle);
    unique case (state_d)
      StSet: begin
        wl_d   = onehot8(row_d);
        bl_d   = data_d;
        wen_d  = 1'b1;
        form_d = (op_d == OpForm);
      end
      StReset: begin
        wen_d = 1'b1;
        if (op_d == OpClear) begin
          wl_d = 8'hFF;
          sl_d = 8'hFF;
        end else begin
          wl_d = onehot8(row_d);
          sl_d = ~data_d;
        end
      end
      StRead, StWait: begin
        mac_d = 1'b1;
        wl_d  = (op_d == OpMac) ? data_d : onehot8(row_d);
      end
      default: ;
    endcase
  end

  // State and registered outputs; reset drops every line asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      op_q        <= OpWrite;
      row_q       <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      bl_q        <= '0;
      wl_q        <= '0;
      sl_q        <= '0;
      wen_q       <= 1'b0;
      form_q      <= 1'b0;
      mac_q       <= 1'b0;
`ifdef CROSSBAR_SEQ_VERIFY_EN
      retry_q     <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      row_q       <= row_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      bl_q        <= bl_d;
      wl_q        <= wl_d;
      sl_q        <= sl_d;
      wen_q       <= wen_d;
      form_q      <= form_d;
      mac_q       <= mac_d;
`ifdef CROSSBAR_SEQ_VERIFY_EN
      retry_q     <= retry_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign cmd_ready_o     = cmd_ready_q;
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_data_o      = rsp_data_q;
  assign busy_o          = busy_q;
  assign xb_bitline_o    = bl_q;
  assign xb_wordline_o   = wl_q;
  assign xb_selectline_o = sl_q;
  assign xb_wenable_o    = wen_q;
  assign xb_form_o       = form_q;
  assign xb_mac_o        = mac_q;

endmodule
